// File: rtl/pmem_pkg.sv
// Shared widths, state encoding and grant encoding for the physical-memory arbiter.
package pmem_pkg;

  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;
  localparam int CNT_W  = $clog2(BEATS);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    I_READ,
    D_READ,
    D_WRITE,
    DONE
  } pmem_arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  // Bursts always start at the first byte of a 32-byte line.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:5], 5'b0};
  endfunction

endpackage

// File: rtl/pmem_line_buffer.sv
// 256-bit line register: full-line load at grant, beat-indexed load on reads,
// beat select for write serialisation.
module pmem_line_buffer
  import pmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_line,
  input  logic [LINE_W-1:0] line_in,
  input  logic              beat_we,
  input  logic [CNT_W-1:0]  beat_idx,
  input  logic [BEAT_W-1:0] beat_in,
  output logic [LINE_W-1:0] line_q,
  output logic [BEAT_W-1:0] beat_out
);

  // Line storage; a full-line load has priority over a beat load.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else if (load_line) begin
      line_q <= line_in;
    end else if (beat_we) begin
      line_q[BEAT_W*beat_idx +: BEAT_W] <= beat_in;
    end
  end

  // Current write beat follows the beat counter.
  always_comb begin
    beat_out = line_q[BEAT_W*beat_idx +: BEAT_W];
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter between icache and dcache line requests onto a single
// 64-bit, four-beat burst memory port.
module pmem_arbiter
  import pmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  pmem_arb_state_t  state_q, state_d;
  grant_t           grant_q, grant_d;
  logic             wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             load_line, beat_we;
  logic             i_req, d_req;
  logic [LINE_W-1:0] line_q;
  logic [BEAT_W-1:0] beat_out;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  pmem_line_buffer u_line (
    .clk      (clk),
    .rst      (rst),
    .load_line(load_line),
    .line_in  (d_wdata),
    .beat_we  (beat_we),
    .beat_idx (cnt_q),
    .beat_in  (pmem_rdata),
    .line_q   (line_q),
    .beat_out (beat_out)
  );

  // Control state: FSM, last grant, write flag and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= GRANT_I;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Burst address is data only; it is captured at grant and gated by state on output.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  // Arbitration, next state and beat bookkeeping.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    load_line = 1'b0;
    beat_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // On a tie, grant whichever side did not win last time.
          if (i_req && d_req) begin
            grant_d = (grant_q == GRANT_I) ? GRANT_D : GRANT_I;
          end else begin
            grant_d = d_req ? GRANT_D : GRANT_I;
          end
          load_line = 1'b1;
          cnt_d     = '0;
          if (grant_d == GRANT_I) begin
            addr_d  = i_address;
            wr_d    = 1'b0;
            state_d = I_READ;
          end else if (d_write) begin
            // A writeback takes precedence over a simultaneous dcache read.
            addr_d  = d_address;
            wr_d    = 1'b1;
            state_d = D_WRITE;
          end else begin
            addr_d  = d_address;
            wr_d    = 1'b0;
            state_d = D_READ;
          end
        end
      end
      I_READ, D_READ: begin
        if (pmem_resp) begin
          beat_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      D_WRITE: begin
        if (pmem_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    pmem_read    = (state_q == I_READ) || (state_q == D_READ);
    pmem_write   = (state_q == D_WRITE);
    pmem_address = (pmem_read || pmem_write) ? line_align(addr_q) : '0;
    pmem_wdata   = pmem_write ? beat_out : '0;
    i_resp       = (state_q == DONE) && (grant_q == GRANT_I);
    d_resp       = (state_q == DONE) && (grant_q == GRANT_D);
    i_rdata      = i_resp ? line_q : '0;
    d_rdata      = (d_resp && !wr_q) ? line_q : '0;
  end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Arbitrates 256-bit cache-line requests from the icache and dcache onto the single 64-bit burst physical-memory port of `mp4`. It sits between the two caches and the `pmem_*` top-level ports. It serialises each line into four 64-bit beats on writes and reassembles four beats into a line on reads. Simultaneous misses are resolved round-robin, so neither cache starves.

## Interface
Parameters:
- none. Widths are fixed by the shared package.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `i_read`  in  1  icache line read request; held until `i_resp`.
- `i_address`  in  32  icache line address.
- `i_rdata`  out  256  assembled line; valid only while `i_resp`=1.
- `i_resp`  out  1  one-cycle completion pulse to icache.
- `d_read`  in  1  dcache line read request; held until `d_resp`.
- `d_write`  in  1  dcache line writeback request; held until `d_resp`.
- `d_address`  in  32  dcache line address.
- `d_wdata`  in  256  writeback line.
- `d_rdata`  out  256  assembled line; valid only while `d_resp`=1.
- `d_resp`  out  1  one-cycle completion pulse to dcache.
- `pmem_read`  out  1  burst read request.
- `pmem_write`  out  1  burst write request.
- `pmem_address`  out  32  line-aligned burst address, `{addr[31:5],5'b0}`.
- `pmem_wdata`  out  64  current write beat.
- `pmem_rdata`  in  64  current read beat.
- `pmem_resp`  in  1  beat acknowledge; one pulse per beat, four per burst, gaps allowed.

## Operation
- States: IDLE, I_READ, D_READ, D_WRITE, DONE.
- IDLE:
  - Request only from icache: grant icache.
  - Request only from dcache: grant dcache.
  - Both requesting: grant the one not granted last (`last_grant` flag).
  - On grant: latch address and `d_wdata`, set the beat counter to 0, update `last_grant`.
  - Go to I_READ, D_READ or D_WRITE.
  - `d_read` and `d_write` both high: write wins.
- I_READ / D_READ:
  - `pmem_read`=1.
  - On each `pmem_resp`, store `pmem_rdata` into `line[64*cnt +: 64]` and increment `cnt`.
  - On the beat with `cnt`=3, go to DONE.
- D_WRITE:
  - `pmem_write`=1, `pmem_wdata`=`line[64*cnt +: 64]`.
  - On each `pmem_resp`, increment `cnt`.
  - On the beat with `cnt`=3, go to DONE.
- DONE:
  - Assert the granted requester's `*_resp` for exactly one cycle.
  - Drive its `*_rdata` from the line buffer; zero on writes.
  - Go to IDLE.
- Requester contract: the requester drops its request in the cycle after `*_resp`. The arbiter never re-grants a request that has not been re-sampled in IDLE.
- `pmem_resp` while in IDLE or DONE is ignored.
- The beat counter is 2 bits and wraps 3→0. The wrap coincides with leaving the transfer state.
- The ungranted requester's `*_resp`=0 and `*_rdata`=0 throughout.

## Timing
- Reset values: state=IDLE, `last_grant`=icache (so the first tie goes to dcache), `cnt`=0, line buffer=0.
- Outputs after reset: all `pmem_*` outputs 0, `i_resp`=`d_resp`=0, `i_rdata`=`d_rdata`=0.
- Reset mid-burst: return to IDLE on the next edge. No `*_resp` is issued. The aborted request must be re-presented.
- All outputs are decoded from registered state, with no combinational path from cache inputs to `pmem_*`.
- Latency:
  - Request sampled in IDLE at cycle 0; `pmem_read`/`pmem_write` high from cycle 1.
  - Last `pmem_resp` at cycle t; `*_resp` at cycle t+1; IDLE at t+2.
  - Back-to-back requests: the second `pmem_*` assertion is no earlier than t+3.
- `pmem_address` holds constant for the whole burst.
- `pmem_read`/`pmem_write` deassert in DONE.

## Structure
- Shared package `pmem_pkg`:
  - constants `LINE_W`=256, `BEAT_W`=64, `BEATS`=4;
  - enum `pmem_arb_state_t`;
  - enum `grant_t` {GRANT_I, GRANT_D}.
- One sub-module, `pmem_line_buffer`: a 256-bit register with beat-indexed load (read path), beat select (write path) and full-line load at grant.
- FSM, counter and arbitration live in `pmem_arbiter`.

## Test plan
- icache read to 0x0000_1234, memory returns beats 0x11..,0x22..,0x33..,0x44..:
  - `pmem_address`=0x0000_1220;
  - `i_rdata`={0x44..,0x33..,0x22..,0x11..};
  - `i_resp` high exactly one cycle, one cycle after beat 4.
- dcache write of line 0xAAAA…_0003_0002_0001_0000 (beats 0,1,2,3):
  - `pmem_wdata` presents beats 0,1,2,3 in order, each held until its `pmem_resp`;
  - `d_resp` follows;
  - `i_resp` stays 0.
- `i_read` and `d_read` asserted together right after reset:
  - dcache served first, then icache;
  - repeat with both held: grants alternate D,I,D,I.
- `pmem_resp` beats separated by 0, 1 and 5 idle cycles: assembled line identical to the gap-free case.
- `rst` asserted after beat 2 of a dcache read:
  - next cycle all outputs 0 and state IDLE, no `d_resp`;
  - re-issued request completes correctly.
- `d_read` and `d_write` both high: a write burst occurs and `d_rdata`=0 at `d_resp`.
